led_pattern_ctrl: RTL and testbench

- Parametrised, multi-channel successor to the board-bring-up LED blinker.
- Drives NUM_LED LEDs, each in one of four modes: off, on, blink with a programmable half-period, or breathe (triangle PWM).
- Sits directly behind the board LED pins and is configured through a simple write port from the CSR/management logic.
- Out of reset, every channel blinks at DEFAULT_HALF_MS, so the board shows life with no software.

---
 rtl/led_pattern_ctrl.sv | 123 ++++++++++++
 tb/tb_led_pattern_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - multi-channel LED pattern generator (off/on/blink/breathe)
module led_pattern_ctrl #(
  parameter int NUM_LED         = 2,
  parameter int CLK_HZ          = 200000000,
  parameter int TICK_HZ         = 1000,
  parameter int PWM_BITS        = 8,
  parameter int DEFAULT_HALF_MS = 500,
  parameter bit LED_ACTIVE_LOW  = 1'b0
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [15:0]        cfg_half_period,
  output logic               tick,
  output logic [NUM_LED-1:0] led
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0]     PS_LAST    = PS_W'(DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE   = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] DUTY_NEAR  = DUTY_MAX - DUTY_ONE;
  localparam logic [15:0]         HP_RST     = 16'(DEFAULT_HALF_MS);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  logic [PS_W-1:0]     prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;

  mode_t               mode        [NUM_LED];
  logic [15:0]         half_period [NUM_LED];
  logic [15:0]         cnt         [NUM_LED];
  logic [15:0]         hp_last     [NUM_LED];
  logic [PWM_BITS-1:0] duty        [NUM_LED];
  logic [NUM_LED-1:0]  phase;
  logic [NUM_LED-1:0]  dir_down;
  logic [NUM_LED-1:0]  level;

  // Time base: prescaler wraps every DIV cycles, tick registered one cycle after the wrap value.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      prescaler <= '0;
      tick      <= 1'b0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
      tick      <= (prescaler == PS_LAST);
      pwm_cnt   <= pwm_cnt + 1'b1;
    end
  end

  // Per-channel blink terminal count (half_period 0 treated as 1) and the resulting LED level.
  always_comb begin
    level = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      hp_last[i] = (half_period[i] == 16'd0) ? 16'd0 : half_period[i] - 16'd1;
      case (mode[i])
        MODE_OFF:     level[i] = 1'b0;
        MODE_ON:      level[i] = 1'b1;
        MODE_BLINK:   level[i] = phase[i];
        MODE_BREATHE: level[i] = (pwm_cnt < duty[i]);
        default:      level[i] = 1'b0;
      endcase
    end
  end

  // Channel state: a config write restarts the channel and wins over a coincident tick.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LED; i++) begin
        mode[i]        <= MODE_BLINK;
        half_period[i] <= HP_RST;
        cnt[i]         <= '0;
        duty[i]        <= '0;
      end
      phase    <= '0;
      dir_down <= '0;
    end else begin
      for (int i = 0; i < NUM_LED; i++) begin
        if (cfg_we && (cfg_ch == 4'(i))) begin
          mode[i]        <= mode_t'(cfg_mode);
          half_period[i] <= cfg_half_period;
          cnt[i]         <= '0;
          phase[i]       <= 1'b0;
          duty[i]        <= '0;
          dir_down[i]    <= 1'b0;
        end else if (tick) begin
          if (mode[i] == MODE_BLINK) begin
            if (cnt[i] >= hp_last[i]) begin
              cnt[i]   <= '0;
              phase[i] <= ~phase[i];
            end else begin
              cnt[i] <= cnt[i] + 16'd1;
            end
          end else if (mode[i] == MODE_BREATHE) begin
            if (!dir_down[i]) begin
              if (duty[i] != DUTY_MAX) duty[i] <= duty[i] + DUTY_ONE;
              if (duty[i] >= DUTY_NEAR) dir_down[i] <= 1'b1;
            end else begin
              if (duty[i] != '0) duty[i] <= duty[i] - DUTY_ONE;
              if (duty[i] <= DUTY_ONE) dir_down[i] <= 1'b0;
            end
          end
        end
      end
    end
  end

  // Registered pin drive with board polarity applied.
  always_ff @(posedge sys_clk) begin
    if (rst) led <= {NUM_LED{LED_ACTIVE_LOW}};
    else     led <= level ^ {NUM_LED{LED_ACTIVE_LOW}};
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - randomized self-checking bench for led_pattern_ctrl
module tb_led_pattern_ctrl;
  localparam int NL   = 2;
  localparam int DIV  = 10;
  localparam int PB   = 4;
  localparam int DH   = 3;
  localparam int DMAX = (1 << PB) - 1;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_hp = '0;
  logic        tick_a, tick_b;
  logic [1:0]  led_a, led_b;

  int tests_run = 0;
  int tests_failed = 0;

  // Abstract model: edges since reset, and per channel the ticks consumed since its last restart.
  int         m_n = 0;
  logic       m_tick = 1'b0;
  logic [1:0] m_led = '0;
  int         m_mode [NL];
  int         m_hp   [NL];
  int         m_k    [NL];

  always #5 sys_clk = ~sys_clk;

  led_pattern_ctrl #(.NUM_LED(NL), .CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(PB),
                     .DEFAULT_HALF_MS(DH), .LED_ACTIVE_LOW(1'b0)) dut_hi (
    .sys_clk(sys_clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half_period(cfg_hp), .tick(tick_a), .led(led_a));

  led_pattern_ctrl #(.NUM_LED(NL), .CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(PB),
                     .DEFAULT_HALF_MS(DH), .LED_ACTIVE_LOW(1'b1)) dut_lo (
    .sys_clk(sys_clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half_period(cfg_hp), .tick(tick_b), .led(led_b));

  function automatic int duty_of(int k);
    int r;
    r = k % (2 * DMAX);
    return (r <= DMAX) ? r : (2 * DMAX - r);
  endfunction

  function automatic logic level_of(int i);
    int hp;
    case (m_mode[i])
      0: return 1'b0;
      1: return 1'b1;
      2: begin
        hp = (m_hp[i] == 0) ? 1 : m_hp[i];
        return ((m_k[i] / hp) % 2) == 1;
      end
      default: return (m_n % (DMAX + 1)) < duty_of(m_k[i]);
    endcase
  endfunction

  task automatic step();
    logic [1:0] nl;
    for (int i = 0; i < NL; i++) nl[i] = level_of(i);
    @(posedge sys_clk);
    if (rst) begin
      m_n = 0; m_tick = 1'b0; m_led = '0;
      for (int i = 0; i < NL; i++) begin m_mode[i] = 2; m_hp[i] = DH; m_k[i] = 0; end
    end else begin
      m_led = nl;
      for (int i = 0; i < NL; i++) begin
        if (cfg_we && (int'(cfg_ch) == i)) begin
          m_mode[i] = int'(cfg_mode); m_hp[i] = int'(cfg_hp); m_k[i] = 0;
        end else if (m_tick && m_mode[i] >= 2) begin
          m_k[i]++;
        end
      end
      m_n++;
      m_tick = (m_n % DIV) == 0;
    end
    #1;
  endtask

  task automatic write(input int ch, input int md, input int hp);
    cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_mode = 2'(md); cfg_hp = 16'(hp);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    int first;
    rst = 1'b1; step(); step();
    tests_run++;
    if (led_a !== 2'b00 || led_b !== 2'b11 || tick_a !== 1'b0 || tick_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state led=%b led_n=%b tick=%b%b want 00 11 00", led_a, led_b, tick_a, tick_b);
    end
    rst = 1'b0;
    first = -1;
    for (int c = 1; c <= 90; c++) begin
      step();
      if (first < 0 && tick_a === 1'b1) first = c;
      tests_run++;
      if (led_a !== m_led || led_b !== ~m_led || tick_a !== m_tick || tick_b !== m_tick || led_a[1] !== led_a[0]) begin
        tests_failed++;
        $display("FAIL reset_blink c=%0d led=%b led_n=%b tick=%b want led=%b tick=%b", c, led_a, led_b, tick_a, m_led, m_tick);
      end
    end
    tests_run++;
    if (first != DIV) begin
      tests_failed++;
      $display("FAIL first_tick cycle=%0d want %0d", first, DIV);
    end
  endtask

  task automatic test_static();
    write(0, 0, 0);
    write(1, 1, 0);
    step();
    tests_run++;
    if (led_a !== 2'b10 || led_b !== 2'b01) begin
      tests_failed++;
      $display("FAIL static led=%b led_n=%b want 10 01", led_a, led_b);
    end
    for (int c = 0; c < 30; c++) begin
      step();
      tests_run++;
      if (led_a !== m_led || led_b !== ~m_led) begin
        tests_failed++;
        $display("FAIL static_hold c=%0d led=%b want %b", c, led_a, m_led);
      end
    end
  endtask

  task automatic test_period_edge();
    for (int hp = 0; hp < 2; hp++) begin
      write(0, 2, hp);
      for (int c = 0; c < 60; c++) begin
        step();
        tests_run++;
        if (led_a !== m_led || led_b !== ~m_led || tick_a !== m_tick) begin
          tests_failed++;
          $display("FAIL period_hp%0d c=%0d led=%b tick=%b want led=%b tick=%b", hp, c, led_a, tick_a, m_led, m_tick);
        end
      end
    end
  endtask

  task automatic test_breathe();
    write(1, 3, 0);
    for (int c = 0; c < 35 * DIV; c++) begin
      step();
      tests_run++;
      if (led_a !== m_led || led_b !== ~m_led) begin
        tests_failed++;
        $display("FAIL breathe c=%0d duty=%0d led=%b want %b", c, duty_of(m_k[1]), led_a, m_led);
      end
    end
  endtask

  task automatic test_collision();
    int guard;
    write(1, 2, 2);
    guard = 0;
    while (!m_tick && guard < 3 * DIV) begin step(); guard++; end
    tests_run++;
    if (!m_tick) begin
      tests_failed++;
      $display("FAIL collision_sync no tick within %0d cycles", guard);
    end
    write(0, 2, 3);
    for (int c = 0; c < 6 * DIV; c++) begin
      step();
      tests_run++;
      if (led_a !== m_led || (c < 2 * DIV && led_a[0] !== 1'b0)) begin
        tests_failed++;
        $display("FAIL collision c=%0d led=%b want %b", c, led_a, m_led);
      end
    end
  endtask

  task automatic test_invalid();
    write(5, 0, 0);
    write(15, 1, 7);
    for (int c = 0; c < 40; c++) begin
      step();
      tests_run++;
      if (led_a !== m_led || led_b !== ~m_led) begin
        tests_failed++;
        $display("FAIL invalid_ch c=%0d led=%b want %b", c, led_a, m_led);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    int first;
    write(1, 3, 0);
    guard = 0;
    while (m_k[1] != 9 && guard < 20 * DIV) begin step(); guard++; end
    rst = 1'b1; cfg_we = 1'b1; cfg_ch = 4'd0; cfg_mode = 2'd1; cfg_hp = 16'd9;
    step();
    rst = 1'b0; cfg_we = 1'b0;
    tests_run++;
    if (guard >= 20 * DIV || led_a !== 2'b00 || led_b !== 2'b11 || tick_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid guard=%0d led=%b led_n=%b tick=%b want 00 11 0", guard, led_a, led_b, tick_a);
    end
    first = -1;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (first < 0 && tick_a === 1'b1) first = c;
      tests_run++;
      if (led_a !== m_led || tick_a !== m_tick) begin
        tests_failed++;
        $display("FAIL reset_mid_run c=%0d led=%b tick=%b want led=%b tick=%b", c, led_a, tick_a, m_led, m_tick);
      end
    end
    tests_run++;
    if (first != DIV) begin
      tests_failed++;
      $display("FAIL reset_mid_tick cycle=%0d want %0d", first, DIV);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_ch   = 4'($urandom_range(0, 3));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_hp   = 16'($urandom_range(0, 4));
      step();
      tests_run++;
      if (led_a !== m_led || led_b !== ~m_led || tick_a !== m_tick || tick_b !== m_tick) begin
        tests_failed++;
        $display("FAIL random c=%0d led=%b tick=%b want led=%b tick=%b", c, led_a, tick_a, m_led, m_tick);
      end
    end
    rst = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_static();
    test_period_edge();
    test_breathe();
    test_collision();
    test_invalid();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
